fft_bfly2_stage: RTL and testbench
==================================

// Module: fft_bfly2_stage
// PURPOSE
//  Radix-2 DIF butterfly stage (stage 02) of the streaming FFT datapath.
//  - Input: NUM complex samples per beat. Frames are DATA samples long.
//  - Pairs sample k with sample k+DATA/2 of the same frame.
//  - Outputs the sum, and the difference rotated by a trivial twiddle (1 or -j).
//  - Results are rescaled to the <9.13> format consumed by the next twiddle-multiply stage.
// PARAMETERS
//  IN_WIDTH   14   signed input width, Q<7.6>
//  OUT_WIDTH  23   signed output width, Q<9.13>
//  NUM        16   lanes (samples) per beat
//  DATA       128  frame length in samples; must be a multiple of 2*NUM
// PORTS
//  clk        in   1                    rising-edge clock
//  rstn       in   1                    synchronous, active-high reset (1 = reset, sampled on clk)
//  din_i      in   [NUM][IN_WIDTH]      real part, lane j = sample base+j
//  din_q      in   [NUM][IN_WIDTH]      imaginary part
//  valid_in   in   1                    din_* holds a valid beat this cycle
//  do1_re     out  [NUM][OUT_WIDTH]     sum output, real
//  do1_im     out  [NUM][OUT_WIDTH]     sum output, imaginary
//  do2_re     out  [NUM][OUT_WIDTH]     twiddled difference, real
//  do2_im     out  [NUM][OUT_WIDTH]     twiddled difference, imaginary
//  valid_out  out  1                    do* valid this cycle
// BEHAVIOUR
//  - Beat counter bcnt: 0..DATA/NUM-1 (0..7 at defaults).
//    - Advances only on cycles with valid_in=1; wraps to 0 after the last beat.
//    - Gaps in valid_in are allowed anywhere and stall the counter.
//  - First half (bcnt < H, where H = DATA/(2*NUM) = 4):
//    - Write din into buffer slot bcnt.
//    - No output for these beats.
//  - Second half (bcnt >= H), with buffered sample a = buf[bcnt-H][j] and arriving sample b = din[j]:
//    - s = a + b, d = a - b, computed at IN_WIDTH+1 bits.
//    - k = (bcnt-H)*NUM + j.
//    - k < DATA/4: t = d.
//    - k >= DATA/4: t = d * (-j), i.e. t_re = d_im, t_im = -d_re.
//    - Scale: out = sign_extend(x, OUT_WIDTH) <<< 7. Shift of 7 is (13-6) fractional bits; never overflows.
//    - do1 = scaled s, do2 = scaled t.
//  - Latency: outputs registered; valid_out=1 exactly one clk after each second-half input beat.
//    - One frame therefore yields H consecutive valid_out pulses if the input was gap-free.
//  - While valid_out=0, do* hold their last values.
//  - Reset: bcnt=0, valid_out=0, all do* = 0. Buffer contents are don't-care.
//    - Reset mid-frame discards the partial frame.
//    - The next valid beat is treated as beat 0 of a new frame.
//  - Back-to-back frames with no idle cycle are supported. The slot being read is freed before the next frame's first-half write reaches it.
//  - Arithmetic is two's complement throughout. No rounding or saturation.
// STRUCTURE
//  - Package fft_pkg holds:
//    - IN_WIDTH / OUT_WIDTH / NUM defaults
//    - localparam SCALE_SHIFT = 7
//    - typedef cplx_in_t and typedef cplx_out_t (packed re/im structs)
//  - Sub-module bfly2_lane: one lane's add/sub, the -j swap-negate selected by input rot, and the <<<7 scaling.
//    - Instantiate NUM times with a generate loop.
//  - Top level holds: beat counter, H x NUM buffer, output registers.
// TESTING
//  - Const frame: first half re=100, im=0; second half re=20, im=0.
//    -> do1_re=15360, do1_im=0 on all lanes.
//    -> k<32: do2_re=10240, do2_im=0.
//    -> k>=32: do2_re=0, do2_im=-10240.
//  - Negative extremes: a=-8192, b=-8192 (re).
//    -> do1_re=-2097152, do2_re=0.
//    - Also a=8191, b=-8192 -> do2_re=16383<<7=2097024.
//  - Imag path: a im=50, b im=10, re=0, lane k>=32.
//    -> do2_re=5120, do2_im=0, do1_im=7680.
//  - Gapped input: insert 3 idle cycles between each of the 8 beats.
//    -> valid_out high exactly 4 times, each one cycle after beats 5..8.
//    -> Data identical to the gap-free run.
//  - Two frames back-to-back (256 ramp samples, re=index, im=0).
//    -> 8 output beats.
//    -> do1_re[k]=(2*base+2k+64)<<7 per frame, where base = frame start index.
//  - Reset asserted after beat 3 of a frame.
//    -> valid_out=0 and do*=0 next cycle.
//    -> A following full frame produces correct outputs.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared widths, complex sample types and the output rescale helper for the
// radix-2 butterfly stage.
package fft_pkg;

    localparam int DEF_IN_WIDTH  = 14;
    localparam int DEF_OUT_WIDTH = 23;
    localparam int DEF_NUM       = 16;
    localparam int DEF_DATA      = 128;
    localparam int SCALE_SHIFT   = 7;

    typedef struct packed {
        logic signed [DEF_IN_WIDTH-1:0] re;
        logic signed [DEF_IN_WIDTH-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [DEF_OUT_WIDTH-1:0] re;
        logic signed [DEF_OUT_WIDTH-1:0] im;
    } cplx_out_t;

    // Q<8.6> sum/difference -> Q<9.13>: sign-extend, then move the binary point.
    function automatic logic signed [DEF_OUT_WIDTH-1:0] scale_out(
        input logic signed [DEF_IN_WIDTH:0] x
    );
        return {{(DEF_OUT_WIDTH-DEF_IN_WIDTH-1-SCALE_SHIFT){x[DEF_IN_WIDTH]}},
                x, {SCALE_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/bfly2_lane.sv
// One butterfly lane: a+b and a-b at one guard bit, optional -j rotation of the
// difference, then rescale to the output format.
module bfly2_lane
    import fft_pkg::*;
(
    input  cplx_in_t  a_i,
    input  cplx_in_t  b_i,
    input  logic      rot_i,
    output cplx_out_t sum_o,
    output cplx_out_t dif_o
);

    logic signed [DEF_IN_WIDTH:0] s_re, s_im, d_re, d_im, t_re, t_im;

    always_comb begin
        s_re = {a_i.re[DEF_IN_WIDTH-1], a_i.re} + {b_i.re[DEF_IN_WIDTH-1], b_i.re};
        s_im = {a_i.im[DEF_IN_WIDTH-1], a_i.im} + {b_i.im[DEF_IN_WIDTH-1], b_i.im};
        d_re = {a_i.re[DEF_IN_WIDTH-1], a_i.re} - {b_i.re[DEF_IN_WIDTH-1], b_i.re};
        d_im = {a_i.im[DEF_IN_WIDTH-1], a_i.im} - {b_i.im[DEF_IN_WIDTH-1], b_i.im};
        t_re = d_re;
        t_im = d_im;
        // Multiply by -j: (re, im) -> (im, -re). The guard bit keeps -d_re in range.
        if (rot_i) begin
            t_re = d_im;
            t_im = -d_re;
        end
    end

    assign sum_o.re = scale_out(s_re);
    assign sum_o.im = scale_out(s_im);
    assign dif_o.re = scale_out(t_re);
    assign dif_o.im = scale_out(t_im);

endmodule

// File: rtl/fft_bfly2_stage.sv
// Radix-2 DIF butterfly stage: buffers the first half-frame, pairs it with the
// second half as it arrives and registers sum / twiddled difference per lane.
module fft_bfly2_stage
    import fft_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int NUM       = DEF_NUM,
    parameter int DATA      = DEF_DATA
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM-1:0][IN_WIDTH-1:0]      din_i,
    input  logic [NUM-1:0][IN_WIDTH-1:0]      din_q,
    input  logic                              valid_in,
    output logic [NUM-1:0][OUT_WIDTH-1:0]     do1_re,
    output logic [NUM-1:0][OUT_WIDTH-1:0]     do1_im,
    output logic [NUM-1:0][OUT_WIDTH-1:0]     do2_re,
    output logic [NUM-1:0][OUT_WIDTH-1:0]     do2_im,
    output logic                              valid_out
);

    localparam int BEATS   = DATA / NUM;
    localparam int H       = BEATS / 2;
    localparam int CW      = $clog2(BEATS);
    localparam int SW      = (H > 1) ? $clog2(H) : 1;
    localparam int QUARTER = DATA / 4;

    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          second_half;
    logic [CW-1:0] rd_beat;
    logic [SW-1:0] wr_slot, rd_slot;

    cplx_in_t  cur     [NUM];
    cplx_in_t  buf_q   [H][NUM];
    cplx_out_t sum     [NUM];
    cplx_out_t dif     [NUM];
    logic [NUM-1:0] rot;

    logic [NUM-1:0][OUT_WIDTH-1:0] do1_re_q, do1_re_d, do1_im_q, do1_im_d;
    logic [NUM-1:0][OUT_WIDTH-1:0] do2_re_q, do2_re_d, do2_im_q, do2_im_d;
    logic                          valid_out_q, valid_out_d;

    assign second_half = (bcnt_q >= CW'(H));
    assign rd_beat     = bcnt_q - CW'(H);
    assign wr_slot     = SW'(bcnt_q);
    assign rd_slot     = SW'(rd_beat);

    always_comb begin
        bcnt_d = bcnt_q;
        if (valid_in) begin
            bcnt_d = (bcnt_q == CW'(BEATS-1)) ? '0 : bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    // A slot is read on the same beat that frees it, so the next frame's
    // first-half write into that slot can never clobber unread data.
    always_ff @(posedge clk) begin
        if (valid_in && !second_half) begin
            for (int j = 0; j < NUM; j++) begin
                buf_q[wr_slot][j] <= cur[j];
            end
        end
    end

    for (genvar j = 0; j < NUM; j++) begin : g_lane
        assign cur[j].re = din_i[j];
        assign cur[j].im = din_q[j];
        assign rot[j]    = (int'(rd_beat) * NUM + j) >= QUARTER;

        bfly2_lane u_lane (
            .a_i   (buf_q[rd_slot][j]),
            .b_i   (cur[j]),
            .rot_i (rot[j]),
            .sum_o (sum[j]),
            .dif_o (dif[j])
        );
    end

    always_comb begin
        do1_re_d    = do1_re_q;
        do1_im_d    = do1_im_q;
        do2_re_d    = do2_re_q;
        do2_im_d    = do2_im_q;
        valid_out_d = valid_in && second_half;
        if (valid_out_d) begin
            for (int j = 0; j < NUM; j++) begin
                do1_re_d[j] = sum[j].re;
                do1_im_d[j] = sum[j].im;
                do2_re_d[j] = dif[j].re;
                do2_im_d[j] = dif[j].im;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            do1_re_q    <= '0;
            do1_im_q    <= '0;
            do2_re_q    <= '0;
            do2_im_q    <= '0;
            valid_out_q <= 1'b0;
        end else begin
            do1_re_q    <= do1_re_d;
            do1_im_q    <= do1_im_d;
            do2_re_q    <= do2_re_d;
            do2_im_q    <= do2_im_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign do1_re    = do1_re_q;
    assign do1_im    = do1_im_q;
    assign do2_re    = do2_re_q;
    assign do2_im    = do2_im_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_fft_bfly2_stage.sv
// Self-checking bench for fft_bfly2_stage: constant-frame vector table, gapped
// and back-to-back frames, mid-frame reset and random frames vs a frame model.
module tb_fft_bfly2_stage;

    localparam int NUM   = 16;
    localparam int IW    = 14;
    localparam int OW    = 23;
    localparam int DATA  = 128;
    localparam int HALF  = DATA / 2;
    localparam int BEATS = DATA / NUM;
    localparam int HB    = BEATS / 2;

    typedef logic [NUM-1:0][OW-1:0] ovec_t;

    typedef struct {
        int a_re; int a_im; int b_re; int b_im;
        int s_re; int s_im;
        int lo_re; int lo_im;
        int hi_re; int hi_im;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b1;
    logic                  valid_in = 1'b0;
    logic [NUM-1:0][IW-1:0] din_i = '0;
    logic [NUM-1:0][IW-1:0] din_q = '0;
    ovec_t                 do1_re, do1_im, do2_re, do2_im;
    logic                  valid_out;

    always #5 clk = ~clk;

    fft_bfly2_stage dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_i     (din_i),
        .din_q     (din_q),
        .valid_in  (valid_in),
        .do1_re    (do1_re),
        .do1_im    (do1_im),
        .do2_re    (do2_re),
        .do2_im    (do2_im),
        .valid_out (valid_out)
    );

    int checks = 0;
    int errors = 0;
    int vo_cnt = 0;

    int fr_re [DATA];
    int fr_im [DATA];
    int ex1r  [HALF];
    int ex1i  [HALF];
    int ex2r  [HALF];
    int ex2i  [HALF];

    // Expectation attached to the beat currently on the inputs.
    logic  exp_n = 1'b0;
    ovec_t e1r = '0, e1i = '0, e2r = '0, e2i = '0;
    // Expectation for the outputs after the last clock edge (held when idle).
    logic  pv = 1'b0;
    ovec_t p1r = '0, p1i = '0, p2r = '0, p2i = '0;

    vec_t tbl [5];

    task automatic check_vec(input string name, input ovec_t act, input ovec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rstn) begin
            pv  = 1'b0;
            p1r = '0; p1i = '0; p2r = '0; p2i = '0;
        end else if (exp_n) begin
            pv  = 1'b1;
            p1r = e1r; p1i = e1i; p2r = e2r; p2i = e2i;
        end else begin
            pv  = 1'b0;
        end
        #1;
        checks++;
        if (valid_out !== pv) begin
            errors++;
            $display("FAIL valid_out got=%b exp=%b t=%0t", valid_out, pv, $time);
        end
        if (valid_out === 1'b1) vo_cnt++;
        check_vec("do1_re", do1_re, p1r);
        check_vec("do1_im", do1_im, p1i);
        check_vec("do2_re", do2_re, p2r);
        check_vec("do2_im", do2_im, p2i);
    end

    // Frame-level reference: pair k with k+DATA/2, rotate the upper quarter by -j.
    function automatic void model_expected();
        int d_re, d_im;
        for (int k = 0; k < HALF; k++) begin
            d_re    = fr_re[k] - fr_re[k+HALF];
            d_im    = fr_im[k] - fr_im[k+HALF];
            ex1r[k] = (fr_re[k] + fr_re[k+HALF]) * 128;
            ex1i[k] = (fr_im[k] + fr_im[k+HALF]) * 128;
            if (k < DATA/4) begin
                ex2r[k] = d_re * 128;
                ex2i[k] = d_im * 128;
            end else begin
                ex2r[k] = d_im * 128;
                ex2i[k] = -d_re * 128;
            end
        end
    endfunction

    function automatic void random_frame();
        for (int n = 0; n < DATA; n++) begin
            fr_re[n] = int'($urandom_range(16383)) - 8192;
            fr_im[n] = int'($urandom_range(16383)) - 8192;
        end
        model_expected();
    endfunction

    function automatic void load_table(input int i);
        for (int n = 0; n < DATA; n++) begin
            fr_re[n] = (n < HALF) ? tbl[i].a_re : tbl[i].b_re;
            fr_im[n] = (n < HALF) ? tbl[i].a_im : tbl[i].b_im;
        end
        for (int k = 0; k < HALF; k++) begin
            ex1r[k] = tbl[i].s_re;
            ex1i[k] = tbl[i].s_im;
            ex2r[k] = (k < DATA/4) ? tbl[i].lo_re : tbl[i].hi_re;
            ex2i[k] = (k < DATA/4) ? tbl[i].lo_im : tbl[i].hi_im;
        end
    endfunction

    task automatic drive_beat(input int b);
        int k;
        @(negedge clk);
        rstn     = 1'b0;
        valid_in = 1'b1;
        for (int j = 0; j < NUM; j++) begin
            din_i[j] = IW'(fr_re[b*NUM+j]);
            din_q[j] = IW'(fr_im[b*NUM+j]);
        end
        exp_n = (b >= HB);
        if (exp_n) begin
            for (int j = 0; j < NUM; j++) begin
                k      = (b - HB) * NUM + j;
                e1r[j] = OW'(ex1r[k]);
                e1i[j] = OW'(ex1i[k]);
                e2r[j] = OW'(ex2r[k]);
                e2i[j] = OW'(ex2i[k]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rstn     = 1'b0;
            valid_in = 1'b0;
            exp_n    = 1'b0;
            for (int j = 0; j < NUM; j++) begin
                din_i[j] = IW'($urandom);
                din_q[j] = IW'($urandom);
            end
        end
    endtask

    // gap < 0 selects a random 0..3 idle cycles after every beat.
    task automatic drive_frame(input int gap, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            drive_beat(b);
            if (gap > 0) idle(gap);
            else if (gap < 0) idle(int'($urandom_range(3)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b1;
        valid_in = 1'b0;
        exp_n    = 1'b0;
        @(posedge clk);
        #2;
        check_vec("rst_do1_re", do1_re, '0);
        check_int("rst_valid_out", int'(valid_out), 0);
        @(negedge clk);
        rstn = 1'b0;
    endtask

    initial begin
        tbl[0] = '{100, 0, 20, 0, 15360, 0, 10240, 0, 0, -10240};
        tbl[1] = '{-8192, 0, -8192, 0, -2097152, 0, 0, 0, 0, 0};
        tbl[2] = '{8191, 0, -8192, 0, -128, 0, 2097024, 0, 0, -2097024};
        tbl[3] = '{0, 50, 0, 10, 0, 7680, 0, 5120, 5120, 0};
        tbl[4] = '{-8192, 8191, 8191, -8192, -128, -128,
                   -2097024, 2097024, 2097024, 2097024};

        rstn = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load_table(i);
            vo_cnt = 0;
            drive_frame(0, BEATS);
            idle(2);
            check_int("tbl_vo_cnt", vo_cnt, HB);
        end

        load_table(0);
        vo_cnt = 0;
        drive_frame(3, BEATS);
        idle(2);
        check_int("gap_vo_cnt", vo_cnt, HB);

        vo_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < DATA; n++) begin
                fr_re[n] = f*DATA + n;
                fr_im[n] = 0;
            end
            for (int k = 0; k < HALF; k++) begin
                ex1r[k] = (2*f*DATA + 2*k + 64) * 128;
                ex1i[k] = 0;
                ex2r[k] = (k < DATA/4) ? -8192 : 0;
                ex2i[k] = (k < DATA/4) ? 0 : 8192;
            end
            drive_frame(0, BEATS);
        end
        idle(2);
        check_int("b2b_vo_cnt", vo_cnt, 2*HB);

        random_frame();
        drive_frame(0, 3);
        do_reset();
        random_frame();
        vo_cnt = 0;
        drive_frame(0, BEATS);
        idle(2);
        check_int("rst3_vo_cnt", vo_cnt, HB);

        random_frame();
        drive_frame(1, 6);
        do_reset();
        random_frame();
        vo_cnt = 0;
        drive_frame(0, BEATS);
        idle(2);
        check_int("rst6_vo_cnt", vo_cnt, HB);

        vo_cnt = 0;
        for (int r = 0; r < 8; r++) begin
            random_frame();
            drive_frame((r % 2 == 1) ? -1 : 0, BEATS);
        end
        idle(3);
        check_int("rand_vo_cnt", vo_cnt, 8*HB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
